// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- hazard detection and forwarding control for a
// five-stage pipeline that also has a multi-cycle multiplier.
//
// Build option: HAZARD_SCOREBOARD_STATS_EN adds a saturating 32-bit
// stall_cnt output that counts stalled cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   Branch_ID                  taken branch in ID
//   rs1use_ID/rs2use_ID        ID instruction reads rs1 / rs2
//   rduse_ID                   ID instruction writes rd
//   hazard_optype_ID [2:0]     0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MUL (5..7 = NONE)
//   rs1_ID, rs2_ID, rd_ID      ID register indices
//   rd_EXE, rd_MEM, rs2_EXE    downstream register indices
//   PC_EN_IF .. reg_MW_EN      pipeline-register enables / stall / flush
//   forward_ctrl_A/B [1:0]     01 EXE ALU, 10 MEM ALU, 11 MEM LOAD, 00 none
//   forward_ctrl_ls            forward MEM load data into an EXE store
//   mul_busy                   multiplier occupied
//   stall_cnt [31:0]           (stats build only) stalled-cycle counter
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic              rduse_ID,
  input  logic [2:0]        hazard_optype_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_stall,
  output logic              reg_FD_flush,
  output logic              reg_DE_EN,
  output logic              reg_DE_flush,
  output logic              reg_EM_EN,
  output logic              reg_EM_flush,
  output logic              reg_MW_EN,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              mul_busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ALU   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} mul_state_e;

  logic [2:0]        optype_id_s;
  logic [2:0]        optype_exe_r;
  logic [2:0]        optype_mem_r;
  mul_state_e        state_r;
  mul_state_e        state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic [REG_AW-1:0] tag_r;
  logic [REG_AW-1:0] tag_nxt_s;
  logic              lu_stall_s;
  logic              mul_stall_s;
  logic              stall_s;
  logic              tag_live_s;

  // Forward select for one source operand; the younger EXE result wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_exe,
    input logic [REG_AW-1:0] rd_mem,
    input logic [2:0]        op_exe,
    input logic [2:0]        op_mem
  );
    logic [1:0] sel;
    if (rs == REG_ZERO) begin
      sel = 2'b00;
    end else if (rs == rd_exe && op_exe == OP_ALU) begin
      sel = 2'b01;
    end else if (rs == rd_mem && op_mem == OP_ALU) begin
      sel = 2'b10;
    end else if (rs == rd_mem && op_mem == OP_LOAD) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Codes 5..7 behave as NONE everywhere, so fold them once here.
  assign optype_id_s = (hazard_optype_ID > OP_MUL) ? OP_NONE : hazard_optype_ID;

  // Load result is not available for an ALU consumer in EXE; a store only
  // needs rs2 in MEM, where forward_ctrl_ls covers it.
  assign lu_stall_s = (optype_exe_r == OP_LOAD) &&
                      ((rs1use_ID && rs1_ID != REG_ZERO && rs1_ID == rd_EXE) ||
                       (rs2use_ID && rs2_ID != REG_ZERO && rs2_ID == rd_EXE &&
                        optype_id_s != OP_STORE));

  assign tag_live_s  = (tag_r != REG_ZERO);
  assign mul_stall_s = (state_r == ST_BUSY) &&
                       ((tag_live_s && rs1use_ID && rs1_ID == tag_r) ||
                        (tag_live_s && rs2use_ID && rs2_ID == tag_r) ||
                        (tag_live_s && rduse_ID  && rd_ID  == tag_r) ||
                        (optype_id_s == OP_MUL));
  assign stall_s = lu_stall_s | mul_stall_s;

  assign PC_EN_IF        = ~stall_s;
  assign reg_FD_stall    = stall_s;
  assign reg_DE_flush    = stall_s;
  // A stalled branch stays in ID and is re-evaluated on the next cycle.
  assign reg_FD_flush    = Branch_ID & ~stall_s;
  assign reg_FD_EN       = 1'b1;
  assign reg_DE_EN       = 1'b1;
  assign reg_EM_EN       = 1'b1;
  assign reg_MW_EN       = 1'b1;
  assign reg_EM_flush    = 1'b0;
  assign forward_ctrl_A  = fwd_sel(rs1_ID, rd_EXE, rd_MEM, optype_exe_r, optype_mem_r);
  assign forward_ctrl_B  = fwd_sel(rs2_ID, rd_EXE, rd_MEM, optype_exe_r, optype_mem_r);
  assign forward_ctrl_ls = (rs2_EXE == rd_MEM) && (rs2_EXE != REG_ZERO) &&
                           (optype_mem_r == OP_LOAD) && (optype_exe_r == OP_STORE);
  assign mul_busy        = (state_r == ST_BUSY);

  // Operation-type shadow of the EXE and MEM stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      optype_exe_r <= OP_NONE;
      optype_mem_r <= OP_NONE;
    end else begin
      optype_exe_r <= reg_DE_flush ? OP_NONE : optype_id_s;
      optype_mem_r <= reg_EM_flush ? OP_NONE : optype_exe_r;
    end
  end

  // Multiplier occupancy: next state, counter and destination tag.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tag_nxt_s   = tag_r;
    case (state_r)
      ST_IDLE: begin
        if (optype_id_s == OP_MUL && !stall_s) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = 4'(MUL_LAT - 1);
          tag_nxt_s   = rd_ID;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Multiplier state register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      tag_r   <= REG_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      tag_r   <= tag_nxt_s;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && stall_cnt_r != 32'hFFFF_FFFF) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with
// expected values taken from the pipeline rules, then a randomized run
// against a cycle-level reference model of the pipeline.
module tb_hazard_scoreboard;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic Branch_ID, rs1use_ID, rs2use_ID, rduse_ID;
  logic [2:0] hazard_optype_ID;
  logic [AW-1:0] rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN;
  logic reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic forward_ctrl_ls, mul_busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state (valid inside test_random only)
  int m_exe, m_mem, m_left, m_tag;
  longint m_cnt;
  int e_stall, e_fa, e_fb, e_ls;

  hazard_scoreboard #(.REG_AW(AW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .Branch_ID(Branch_ID), .rs1use_ID(rs1use_ID),
    .rs2use_ID(rs2use_ID), .rduse_ID(rduse_ID), .hazard_optype_ID(hazard_optype_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .rd_EXE(rd_EXE),
    .rd_MEM(rd_MEM), .rs2_EXE(rs2_EXE), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush), .reg_DE_EN(reg_DE_EN),
    .reg_DE_flush(reg_DE_flush), .reg_EM_EN(reg_EM_EN), .reg_EM_flush(reg_EM_flush),
    .reg_MW_EN(reg_MW_EN), .forward_ctrl_A(forward_ctrl_A),
    .forward_ctrl_B(forward_ctrl_B), .forward_ctrl_ls(forward_ctrl_ls),
    .mul_busy(mul_busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Branch_ID = 1'b0; rs1use_ID = 1'b0; rs2use_ID = 1'b0; rduse_ID = 1'b0;
    hazard_optype_ID = 3'd0;
    rs1_ID = '0; rs2_ID = '0; rd_ID = '0; rd_EXE = '0; rd_MEM = '0; rs2_EXE = '0;
  endtask

  task automatic drain();
    idle_in();
    repeat (LAT + 2) cyc();
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #2;
    total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL reset_mul_busy got=%0b exp=0", mul_busy); end
    total++; if ({forward_ctrl_A, forward_ctrl_B} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {forward_ctrl_A, forward_ctrl_B}); end
    total++; if (PC_EN_IF !== 1'b1) begin bad++; $display("FAIL reset_pc_en got=%0b exp=1", PC_EN_IF); end
    total++; if ({reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN} !== 4'b1111) begin bad++; $display("FAIL reset_enables got=%b exp=1111", {reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN}); end
    total++; if ({reg_FD_flush, reg_DE_flush, reg_EM_flush, forward_ctrl_ls} !== 4'b0000) begin bad++; $display("FAIL reset_flush_ls got=%b exp=0000", {reg_FD_flush, reg_DE_flush, reg_EM_flush, forward_ctrl_ls}); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    cyc();
  endtask

  task automatic test_alu_forward();
    idle_in(); hazard_optype_ID = 3'd1; rd_ID = 5'd5; rduse_ID = 1'b1;
    cyc();
    idle_in(); rd_EXE = 5'd5; rs1_ID = 5'd5; rs1use_ID = 1'b1; hazard_optype_ID = 3'd1; rd_ID = 5'd6; rduse_ID = 1'b1;
    #2;
    total++; if (forward_ctrl_A !== 2'b01) begin bad++; $display("FAIL alu_fwd_exe got=%b exp=01", forward_ctrl_A); end
    total++; if (PC_EN_IF !== 1'b1) begin bad++; $display("FAIL alu_no_stall got=%0b exp=1", PC_EN_IF); end
    cyc();
    idle_in(); rd_EXE = 5'd6; rd_MEM = 5'd5; rs1_ID = 5'd5; rs1use_ID = 1'b1;
    #2;
    total++; if (forward_ctrl_A !== 2'b10) begin bad++; $display("FAIL alu_fwd_mem got=%b exp=10", forward_ctrl_A); end
    drain();
  endtask

  task automatic test_load_use();
    idle_in(); hazard_optype_ID = 3'd2; rd_ID = 5'd7; rduse_ID = 1'b1;
    cyc();
    idle_in(); rd_EXE = 5'd7; hazard_optype_ID = 3'd1; rs2_ID = 5'd7; rs2use_ID = 1'b1;
    #2;
    total++; if ({PC_EN_IF, reg_DE_flush, reg_FD_stall} !== 3'b011) begin bad++; $display("FAIL load_use_stall got=%b exp=011", {PC_EN_IF, reg_DE_flush, reg_FD_stall}); end
    cyc();
    rd_EXE = 5'd0; rd_MEM = 5'd7;
    #2;
    total++; if (PC_EN_IF !== 1'b1) begin bad++; $display("FAIL load_use_release got=%0b exp=1", PC_EN_IF); end
    total++; if (forward_ctrl_B !== 2'b11) begin bad++; $display("FAIL load_fwd_mem got=%b exp=11", forward_ctrl_B); end
    cyc();
    idle_in(); hazard_optype_ID = 3'd2; rd_ID = 5'd7; rduse_ID = 1'b1;
    cyc();
    idle_in(); rd_EXE = 5'd7; rd_MEM = 5'd9; hazard_optype_ID = 3'd3; rs2_ID = 5'd7; rs2use_ID = 1'b1;
    #2;
    total++; if (PC_EN_IF !== 1'b1) begin bad++; $display("FAIL store_no_stall got=%0b exp=1", PC_EN_IF); end
    cyc();
    idle_in(); rs2_EXE = 5'd7; rd_MEM = 5'd7;
    #2;
    total++; if (forward_ctrl_ls !== 1'b1) begin bad++; $display("FAIL store_fwd_ls got=%0b exp=1", forward_ctrl_ls); end
    drain();
  endtask

  task automatic test_mul();
    int n;
    idle_in(); hazard_optype_ID = 3'd4; rd_ID = 5'd3; rduse_ID = 1'b1;
    #2;
    total++; if ({PC_EN_IF, mul_busy} !== 2'b10) begin bad++; $display("FAIL mul_issue got=%b exp=10", {PC_EN_IF, mul_busy}); end
    cyc();
    idle_in(); hazard_optype_ID = 3'd1; rs1_ID = 5'd3; rs1use_ID = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #2;
      total++; if ({PC_EN_IF, mul_busy} !== 2'b01) begin bad++; $display("FAIL mul_raw_cycle%0d got=%b exp=01", i, {PC_EN_IF, mul_busy}); end
      cyc();
    end
    #2;
    total++; if ({PC_EN_IF, mul_busy} !== 2'b10) begin bad++; $display("FAIL mul_raw_release got=%b exp=10", {PC_EN_IF, mul_busy}); end
    cyc();
    idle_in(); hazard_optype_ID = 3'd4; rd_ID = 5'd4; rduse_ID = 1'b1;
    cyc();
    rd_ID = 5'd8;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (PC_EN_IF === 1'b1) break;
      n++;
      cyc();
    end
    total++; if (n != LAT) begin bad++; $display("FAIL mul_b2b_stall got=%0d exp=%0d", n, LAT); end
    cyc();
    idle_in();
    #2;
    total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL mul_b2b_issue got=%0b exp=1", mul_busy); end
    drain();
  endtask

  task automatic test_zero_reg();
    idle_in(); hazard_optype_ID = 3'd4; rd_ID = 5'd0; rduse_ID = 1'b1;
    cyc();
    idle_in(); hazard_optype_ID = 3'd1; rs1_ID = 5'd0; rs1use_ID = 1'b1; rd_ID = 5'd0; rduse_ID = 1'b1;
    #2;
    total++; if ({PC_EN_IF, mul_busy} !== 2'b11) begin bad++; $display("FAIL zero_mul_no_raw got=%b exp=11", {PC_EN_IF, mul_busy}); end
    drain();
    idle_in(); hazard_optype_ID = 3'd2; rd_ID = 5'd0; rduse_ID = 1'b1;
    cyc();
    idle_in(); hazard_optype_ID = 3'd1; rs1use_ID = 1'b1; rs2use_ID = 1'b1;
    #2;
    total++; if ({PC_EN_IF, forward_ctrl_A, forward_ctrl_B} !== 5'b10000) begin bad++; $display("FAIL zero_load_use got=%b exp=10000", {PC_EN_IF, forward_ctrl_A, forward_ctrl_B}); end
    drain();
  endtask

  task automatic test_branch();
    idle_in(); hazard_optype_ID = 3'd2; rd_ID = 5'd7; rduse_ID = 1'b1;
    cyc();
    idle_in(); rd_EXE = 5'd7; rs1_ID = 5'd7; rs1use_ID = 1'b1; Branch_ID = 1'b1;
    #2;
    total++; if ({PC_EN_IF, reg_FD_flush} !== 2'b00) begin bad++; $display("FAIL branch_stalled got=%b exp=00", {PC_EN_IF, reg_FD_flush}); end
    cyc();
    rd_EXE = 5'd0; rd_MEM = 5'd7;
    #2;
    total++; if ({PC_EN_IF, reg_FD_flush} !== 2'b11) begin bad++; $display("FAIL branch_flush got=%b exp=11", {PC_EN_IF, reg_FD_flush}); end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    idle_in(); hazard_optype_ID = 3'd4; rd_ID = 5'd3; rduse_ID = 1'b1;
    cyc();
    idle_in();
    cyc();
    #2;
    total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL rst_mul_busy_before got=%0b exp=1", mul_busy); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    hazard_optype_ID = 3'd1; rs1_ID = 5'd3; rs1use_ID = 1'b1;
    #2;
    total++; if ({mul_busy, PC_EN_IF} !== 2'b01) begin bad++; $display("FAIL rst_mul_abort got=%b exp=01", {mul_busy, PC_EN_IF}); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    drain();
  endtask

  function automatic int mfwd(int rs);
    if (rs == 0) return 0;
    if (rs == int'(rd_EXE) && m_exe == 1) return 1;
    if (rs == int'(rd_MEM) && m_mem == 1) return 2;
    if (rs == int'(rd_MEM) && m_mem == 2) return 3;
    return 0;
  endfunction

  task automatic model_eval();
    int op;
    bit lu, ms;
    op = (hazard_optype_ID > 3'd4) ? 0 : int'(hazard_optype_ID);
    lu = (m_exe == 2) &&
         ((rs1use_ID && rs1_ID != 0 && rs1_ID == rd_EXE) ||
          (rs2use_ID && rs2_ID != 0 && rs2_ID == rd_EXE && op != 3));
    ms = (m_left > 0) &&
         ((m_tag != 0 && rs1use_ID && int'(rs1_ID) == m_tag) ||
          (m_tag != 0 && rs2use_ID && int'(rs2_ID) == m_tag) ||
          (m_tag != 0 && rduse_ID && int'(rd_ID) == m_tag) || op == 4);
    e_stall = (lu || ms) ? 1 : 0;
    e_fa = mfwd(int'(rs1_ID));
    e_fb = mfwd(int'(rs2_ID));
    e_ls = (rs2_EXE == rd_MEM && rs2_EXE != 0 && m_mem == 2 && m_exe == 3) ? 1 : 0;
  endtask

  task automatic model_step();
    int op;
    op = (hazard_optype_ID > 3'd4) ? 0 : int'(hazard_optype_ID);
    if (rst) begin
      m_exe = 0; m_mem = 0; m_left = 0; m_tag = 0; m_cnt = 0;
    end else begin
      m_mem = m_exe;
      m_exe = (e_stall != 0) ? 0 : op;
      if (m_left > 0) m_left--;
      else if (op == 4 && e_stall == 0) begin m_left = LAT; m_tag = int'(rd_ID); end
      if (e_stall != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_ctl, got_ctl;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      Branch_ID = 1'($urandom); rs1use_ID = 1'($urandom); rs2use_ID = 1'($urandom);
      rduse_ID = 1'($urandom);
      hazard_optype_ID = 3'($urandom_range(0, 7));
      rs1_ID = AW'($urandom_range(0, 3)); rs2_ID = AW'($urandom_range(0, 3));
      rd_ID = AW'($urandom_range(0, 3)); rd_EXE = AW'($urandom_range(0, 3));
      rd_MEM = AW'($urandom_range(0, 3)); rs2_EXE = AW'($urandom_range(0, 3));
      #2;
      if (i > 0) begin
        model_eval();
        exp_ctl = {e_stall == 0, e_stall != 0, e_stall != 0, Branch_ID && e_stall == 0,
                   e_ls != 0, m_left > 0};
        got_ctl = {PC_EN_IF, reg_FD_stall, reg_DE_flush, reg_FD_flush, forward_ctrl_ls, mul_busy};
        total++; if (got_ctl !== exp_ctl) begin bad++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, got_ctl, exp_ctl); end
        total++; if (forward_ctrl_A !== 2'(e_fa) || forward_ctrl_B !== 2'(e_fb)) begin
          bad++; $display("FAIL rand_fwd cyc=%0d got=%b/%b exp=%0d/%0d", i, forward_ctrl_A, forward_ctrl_B, e_fa, e_fb);
        end
      end else begin
        e_stall = 0;
      end
      @(posedge clk);
      model_step();
      #1;
    end
`ifdef HAZARD_SCOREBOARD_STATS_EN
    #2;
    total++; if (stall_cnt !== 32'(m_cnt)) begin bad++; $display("FAIL rand_stall_cnt got=%0d exp=%0d", stall_cnt, m_cnt); end
`endif
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mul();
    test_zero_reg();
    test_branch();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter MUL_LAT, default 4, multi-cycle MUL occupancy in cycles (legal 2..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports Branch_ID, rs1use_ID, rs2use_ID, rduse_ID  input  1 each  branch taken / operand-use / destination-write flags of the ID instruction.
REQ-006 SHALL have port hazard_optype_ID  input  3  0=NONE, 1=ALU, 2=LOAD, 3=STORE, 4=MUL; 5..7 treated as NONE.
REQ-007 SHALL have ports rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE  input  REG_AW each  register indices.
REQ-008 SHALL have ports PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN  output  1 each  pipeline-register controls.
REQ-009 SHALL have ports forward_ctrl_A, forward_ctrl_B  output  2 each; forward_ctrl_ls  output  1; mul_busy  output  1.

Function
REQ-010 SHALL register optype_EXE <= optype_ID and optype_MEM <= optype_EXE each cycle, each forced to NONE when the feeding stage is flushed (reg_DE_flush / reg_EM_flush); reg_EM_flush is constant 0.
REQ-011 SHALL treat register index 0 as hazard-free: no stall, no forwarding for any operand equal to 0.
REQ-012 SHALL encode forward_ctrl_A for rs1 (B for rs2): 01 if match rd_EXE with optype_EXE=ALU; else 10 if match rd_MEM with optype_MEM=ALU; else 11 if match rd_MEM with optype_MEM=LOAD; else 00; EXE has priority over MEM.
REQ-013 SHALL raise load-use stall when rsX used, rsX=rd_EXE and optype_EXE=LOAD, except rs2 match when optype_ID=STORE.
REQ-014 SHALL drive forward_ctrl_ls=1 when rs2_EXE=rd_MEM, rs2_EXE!=0, optype_MEM=LOAD and optype_EXE=STORE.
REQ-015 SHALL contain MUL state machine IDLE/BUSY with a 4-bit down-counter and REG_AW-bit tag.
REQ-016 SHALL transition IDLE->BUSY when optype_ID=MUL and no stall is asserted that cycle: counter<=MUL_LAT-1, tag<=rd_ID.
REQ-017 SHALL decrement the counter each BUSY cycle and return to IDLE in the cycle after the counter reads 0; mul_busy=1 exactly while BUSY, i.e. MUL_LAT cycles.
REQ-018 SHALL raise MUL stall while BUSY if: used rs1/rs2 equals tag (RAW), rduse_ID and rd_ID equals tag (WAW), or optype_ID=MUL (structural); tag 0 never causes RAW/WAW.
REQ-019 SHALL define stall = load-use stall OR MUL stall; PC_EN_IF=~stall, reg_FD_stall=stall, reg_DE_flush=stall.
REQ-020 SHALL drive reg_FD_flush=Branch_ID & ~stall (stalled branch re-evaluated next cycle).
REQ-021 SHALL tie reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN to 1.
REQ-022 SHALL keep all outputs other than mul_busy combinational from inputs and registered state (zero latency).

Reset
REQ-023 SHALL on rst set optype_EXE/MEM=NONE, state=IDLE, counter=0, tag=0; consequently mul_busy=0, forwards=00, PC_EN_IF=1 with idle inputs.
REQ-024 SHALL let rst asserted mid-MUL abort to IDLE on the next edge, taking priority over every transition.

Configuration
REQ-025 SHALL, with HAZARD_SCOREBOARD_STATS_EN defined, add output stall_cnt (32 bits) counting cycles with stall=1, saturating at 0xFFFFFFFF, cleared by rst; without the macro the port and counter SHALL not exist.

Verification
REQ-026 SHALL test ALU x5 then ID rs1=5 -> forward_ctrl_A=01, next cycle 10, no stall.
REQ-027 SHALL test LOAD x7 in EXE, ID ADD rs2=7 -> one stall cycle (PC_EN_IF=0, reg_DE_flush=1), then forward_ctrl_B=11; ID STORE rs2=7 -> no stall, next cycle forward_ctrl_ls=1.
REQ-028 SHALL test MUL_LAT=4 MUL x3, then ID rs1=3 -> stall exactly 4 cycles, mul_busy high 4 cycles; back-to-back MUL likewise stalled.
REQ-029 SHALL test MUL x0 then dependent ID rs1=0 -> no RAW stall; LOAD x0 + use -> no stall, forwards 00.
REQ-030 SHALL test Branch_ID=1 with simultaneous load-use stall -> reg_FD_flush=0; next cycle -> reg_FD_flush=1.
REQ-031 SHALL test rst in second BUSY cycle -> mul_busy=0 next cycle, dependent instruction not stalled; with stats macro, stall_cnt=0 after reset.
